// File: rtl/pc_sequencer.sv
// Next-PC sequencer: FETCH/EXEC (+INT when PC_SEQ_INT_EN is defined) with return-address stack.
// pc_ld/pc_data/exec/int_ack are combinational from state; advance is gated by imem_ready and stall.
module pc_sequencer #(
    parameter int             AW      = 10,
    parameter int             DEPTH   = 8,
    parameter logic [AW-1:0]  INT_VEC = 10'h3FF
) (
    input  logic          clk,
    input  logic          RST,
    input  logic [AW-1:0] pc_cur,
    input  logic          imem_ready,
    input  logic          stall,
    input  logic          br_req,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic [AW-1:0] br_addr,
    input  logic          int_req,
    input  logic          int_ie,
    output logic          pc_ld,
    output logic [AW-1:0] pc_data,
    output logic          exec,
    output logic          int_ack,
    output logic          stk_err
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        INT   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [SPW-1:0]  sp, sp_nxt, sp_m1;
    logic [AW-1:0]   stack [DEPTH];
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   push_val;
    logic            wr_en;
    logic            err_set;

    assign pc_inc = pc_cur + AW'(1);
    assign sp_m1  = sp - SPW'(1);

    always_comb begin
        state_nxt = state;
        sp_nxt    = sp;
        pc_ld     = 1'b0;
        pc_data   = '0;
        exec      = 1'b0;
        int_ack   = 1'b0;
        wr_en     = 1'b0;
        push_val  = '0;
        err_set   = 1'b0;
        case (state)
            FETCH: begin
                if (!stall && imem_ready)
                    state_nxt = EXEC;
            end
            EXEC: begin
                exec      = 1'b1;
                pc_ld     = 1'b1;
                state_nxt = FETCH;
                if (call_req) begin
                    pc_data  = br_addr;
                    push_val = pc_inc;
                    if (sp == SP_FULL) begin
                        err_set = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        sp_nxt = sp + SPW'(1);
                    end
                end else if (ret_req) begin
                    if (sp == '0) begin
                        err_set = 1'b1;
                    end else begin
                        pc_data = stack[sp_m1[IW-1:0]];
                        sp_nxt  = sp_m1;
                    end
                end else if (br_req) begin
                    pc_data = br_addr;
                end else begin
                    pc_data = pc_inc;
                end
`ifdef PC_SEQ_INT_EN
                // A full stack (after this EXEC's own push) defers the interrupt.
                if (int_req && int_ie && (sp_nxt != SP_FULL))
                    state_nxt = INT;
`endif
            end
`ifdef PC_SEQ_INT_EN
            INT: begin
                pc_ld     = 1'b1;
                pc_data   = INT_VEC;
                int_ack   = 1'b1;
                push_val  = pc_cur;
                state_nxt = FETCH;
                if (sp == SP_FULL) begin
                    err_set = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    sp_nxt = sp + SPW'(1);
                end
            end
`endif
            default: state_nxt = FETCH;
        endcase
    end

`ifndef PC_SEQ_INT_EN
    logic int_unused;
    assign int_unused = ^{int_req, int_ie, INT_VEC};
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= FETCH;
            sp      <= '0;
            stk_err <= 1'b0;
        end else begin
            state <= state_nxt;
            sp    <= sp_nxt;
            if (err_set)
                stk_err <= 1'b1;
        end
    end

    // Stack storage needs no reset; sp alone defines validity.
    always_ff @(posedge clk) begin
        if (!RST && wr_en)
            stack[sp[IW-1:0]] <= push_val;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a PC-register model feeding pc_cur.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        RST;
    logic [9:0]  pc_cur;
    logic        imem_ready, stall, br_req, call_req, ret_req;
    logic [9:0]  br_addr;
    logic        int_req, int_ie;
    logic        pc_ld;
    logic [9:0]  pc_data;
    logic        exec, int_ack, stk_err;

    logic [9:0]  pc_q;
    logic        force_vld;
    logic [9:0]  force_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .RST(RST), .pc_cur(pc_cur), .imem_ready(imem_ready),
        .stall(stall), .br_req(br_req), .call_req(call_req), .ret_req(ret_req),
        .br_addr(br_addr), .int_req(int_req), .int_ie(int_ie),
        .pc_ld(pc_ld), .pc_data(pc_data), .exec(exec), .int_ack(int_ack),
        .stk_err(stk_err)
    );

    always @(posedge clk) begin
        if (RST)            pc_q <= 10'h000;
        else if (force_vld) pc_q <= force_val;
        else if (pc_ld)     pc_q <= pc_data;
    end
    assign pc_cur = pc_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    // From FETCH: load pc_q with a, land in EXEC with pc_cur = a.
    task automatic go_exec(input logic [9:0] a);
        force_vld = 1'b1;
        force_val = a;
        next();
        force_vld = 1'b0;
    endtask

    initial begin
        RST = 1'b1; imem_ready = 1'b0; stall = 1'b0; br_req = 1'b0;
        call_req = 1'b0; ret_req = 1'b0; br_addr = '0; int_req = 1'b0;
        int_ie = 1'b0; force_vld = 1'b0; force_val = '0;
        next(); next();
        chk("rst_pc_ld", pc_ld, 0);
        chk("rst_pc_data", pc_data, 0);
        chk("rst_exec", exec, 0);
        chk("rst_int_ack", int_ack, 0);
        chk("rst_stk_err", stk_err, 0);
        chk("rst_sp", dut.sp, 0);

        // Sequential increment
        RST = 1'b0; imem_ready = 1'b1;
        #1;
        chk("fetch0_pc_ld", pc_ld, 0);
        for (int i = 1; i <= 3; i++) begin
            next();
            chk("seq_pc_ld", pc_ld, 1);
            chk("seq_exec", exec, 1);
            chk("seq_pc_data", pc_data, i);
            next();
            chk("seq_fetch_pc_ld", pc_ld, 0);
            chk("seq_fetch_exec", exec, 0);
        end

        // Wrap then stall
        go_exec(10'h3FF);
        chk("wrap_pc_data", pc_data, 10'h000);
        stall = 1'b1;
        next();
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc_ld", pc_ld, 0);
            next();
        end
        stall = 1'b0;
        #1;
        chk("stall_pc_ld_last", pc_ld, 0);
        next();
        chk("after_stall_pc_data", pc_data, 10'h001);
        next();

        // Call / return
        go_exec(10'h010);
        call_req = 1'b1; br_addr = 10'h080;
        #1;
        chk("call_pc_data", pc_data, 10'h080);
        next();
        call_req = 1'b0;
        chk("call_sp", dut.sp, 1);
        go_exec(10'h085);
        ret_req = 1'b1;
        #1;
        chk("ret_pc_data", pc_data, 10'h011);
        next();
        ret_req = 1'b0;
        chk("ret_sp", dut.sp, 0);

        // Nine nested calls into an 8-deep stack
        for (int i = 0; i < 9; i++) begin
            go_exec(10'h100 + 10'(i));
            call_req = 1'b1; br_addr = 10'h200 + 10'(i);
            #1;
            chk("ncall_pc_data", pc_data, 10'h200 + 10'(i));
            if (i == 8) chk("ncall8_err_before", stk_err, 0);
            next();
            call_req = 1'b0;
        end
        chk("ovf_stk_err", stk_err, 1);
        chk("ovf_sp", dut.sp, 8);
        for (int i = 0; i < 9; i++) begin
            go_exec(10'h300);
            ret_req = 1'b1;
            #1;
            chk("nret_pc_data", pc_data, (i < 8) ? (10'h108 - 10'(i)) : 10'h000);
            next();
            ret_req = 1'b0;
        end
        chk("unf_sp", dut.sp, 0);
        chk("unf_stk_err", stk_err, 1);
        RST = 1'b1;
        next();
        RST = 1'b0;
        chk("err_cleared", stk_err, 0);

        // Interrupt on a taken branch
        go_exec(10'h020);
        br_req = 1'b1; br_addr = 10'h040; int_req = 1'b1; int_ie = 1'b1;
        #1;
        chk("int_br_pc_data", pc_data, 10'h040);
        next();
        br_req = 1'b0; int_req = 1'b0; int_ie = 1'b0;
`ifdef PC_SEQ_INT_EN
        chk("int_pc_ld", pc_ld, 1);
        chk("int_pc_data", pc_data, 10'h3FF);
        chk("int_ack", int_ack, 1);
        chk("int_exec", exec, 0);
        next();
        go_exec(10'h3FF);
        ret_req = 1'b1;
        #1;
        chk("int_ret_pc_data", pc_data, 10'h040);
        next();
        ret_req = 1'b0;
`else
        chk("noint_pc_ld", pc_ld, 0);
        chk("noint_int_ack", int_ack, 0);
        chk("noint_sp", dut.sp, 0);
`endif
        chk("int_sp_final", dut.sp, 0);

        // Reset mid-EXEC discards the push
        go_exec(10'h060);
        call_req = 1'b1; br_addr = 10'h070; RST = 1'b1;
        next();
        call_req = 1'b0; RST = 1'b0;
        chk("rst_exec_sp", dut.sp, 0);
        chk("rst_exec_pc_ld", pc_ld, 0);

`ifdef PC_SEQ_INT_EN
        // Reset during INT
        go_exec(10'h050);
        int_req = 1'b1; int_ie = 1'b1;
        next();
        int_req = 1'b0; int_ie = 1'b0; RST = 1'b1;
        #1;
        chk("rst_int_in_int", int_ack, 1);
        next();
        RST = 1'b0;
        chk("rst_int_pc_ld", pc_ld, 0);
        chk("rst_int_ack", int_ack, 0);
        chk("rst_int_sp", dut.sp, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control-side counterpart to the program counter register. It computes the next instruction address each instruction and drives the load strobe and load data into the PC register. It handles sequential increment, branch/jump, call/return through an internal return-address stack, and optional interrupt vectoring. It sits between the control unit/branch logic and the PC register, and is gated by an instruction-memory ready handshake.

Parameters:
AW, 10, address width; matches the PC register width.
DEPTH, 8, return-address stack entries; power of two, ≥2.
INT_VEC, 10'h3FF, interrupt vector address loaded on interrupt entry.

Ports:
clk  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
pc_cur  in  AW  current PC value, read back from the PC register output
imem_ready  in  1  instruction memory has valid instruction for pc_cur
stall  in  1  hold in FETCH; no advance
br_req  in  1  branch/jump taken this instruction
call_req  in  1  call: push return address, jump to br_addr
ret_req  in  1  return: pop the stack into the PC
br_addr  in  AW  target for br_req/call_req
int_req  in  1  level interrupt request (INT_EN only)
int_ie  in  1  interrupt enable from the control unit (INT_EN only)
pc_ld  out  1  load strobe to the PC register
pc_data  out  AW  next-PC value to the PC register
exec  out  1  high during the EXEC cycle; the instruction retires this cycle
int_ack  out  1  one-cycle pulse on interrupt entry
stk_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- One clock; reset is synchronous and active-high. clk and RST are the only clock/reset.
- Reset values (RST sampled high at an edge): state=FETCH, stack pointer sp=0, stk_err=0. Therefore pc_ld=0, pc_data=0, exec=0, int_ack=0. Reset overrides any in-flight state, including mid-EXEC and mid-INT.
- pc_ld, pc_data, exec and int_ack are combinational from state plus inputs. When pc_ld=0, pc_data=0.
- The PC register captures pc_data at the edge that ends the cycle in which pc_ld=1. New pc_cur is visible the next cycle.
- State FETCH:
  - Outputs pc_ld=0, exec=0.
  - Go to EXEC when imem_ready=1 and stall=0; otherwise stay in FETCH.
  - stall has priority over imem_ready.
- State EXEC (exactly one cycle):
  - Outputs exec=1, pc_ld=1.
  - pc_data priority: call_req > ret_req > br_req > increment.
  - call_req: pc_data=br_addr; push (pc_cur+1) mod 2^AW.
  - ret_req: pc_data=stack[sp-1]; sp decrements.
  - br_req: pc_data=br_addr.
  - Otherwise: pc_data=(pc_cur+1) mod 2^AW, so 3FF wraps to 000.
  - Next state: INT if interrupt is pending (INT_EN); otherwise FETCH.
- State INT (INT_EN only, one cycle):
  - Outputs pc_ld=1, pc_data=INT_VEC, int_ack=1.
  - Pushes pc_cur, which is the address already loaded in EXEC and serves as the resume address.
  - Next state: FETCH.
- Interrupt pending condition: int_req=1 and int_ie=1 in the EXEC cycle, and the stack is not full. The EXEC redirect still completes first. A stack-full condition defers the interrupt rather than taking it.
- Stack: DEPTH×AW registers. push writes stack[sp], then sp+1. pop reads stack[sp-1], then sp-1.
- Overflow (push when sp=DEPTH): push dropped, sp unchanged, stk_err←1, and the call still jumps.
- Underflow (pop when sp=0): pc_data=0, sp unchanged, stk_err←1.
- stk_err clears only on RST.
- Simultaneous call_req and ret_req: call wins, with no pop.
- Request inputs are ignored outside EXEC.

Optional Feature:
Macro PC_SEQ_INT_EN.
- Defined: INT state, int_req/int_ie sampling, int_ack and the resume-address push are present as described.
- Undefined: no INT state; EXEC always returns to FETCH; int_req and int_ie are ignored; int_ack is tied to 0. The ports remain present.

Test Plan:
- RST=1 for 2 cycles, then imem_ready=1 with no requests, and pc_cur fed back from a PC model: pc_data sequence is 001, 002, 003; pc_ld high on every 2nd cycle (EXEC); exec matches pc_ld.
- pc_cur=3FF, EXEC with no request -> pc_data=000 (wrap). Then stall=1 for 3 cycles -> stays in FETCH, pc_ld=0 throughout.
- pc_cur=010, call_req with br_addr=080 -> pc_data=080. Later at pc_cur=085, ret_req -> pc_data=011; sp returns to 0.
- 9 nested calls with DEPTH=8 -> 9th call still jumps and stk_err=1. Then 9 returns -> 8 correct addresses, 9th gives pc_data=000; stk_err stays 1 until RST.
- PC_SEQ_INT_EN defined; pc_cur=020, int_req=int_ie=1 at EXEC with br_req, br_addr=040 -> EXEC loads 040, next cycle pc_data=3FF with int_ack=1, then ret_req returns to 040. Same stimulus with the macro undefined -> no INT cycle, int_ack=0.
- RST asserted during the INT cycle -> next cycle state=FETCH, sp=0, pc_ld=0, int_ack=0, and no push committed.
